// File: rtl/multi_cycle_ctrl_if.sv
// Control bundle between the multi-cycle CPU controller and its datapath.
// The illegal flag exists only when CTRL_ILLEGAL_TRAP_EN is defined.
interface multi_cycle_ctrl_if #(
  parameter int OP_W = 6
);
  logic [OP_W-1:0] opcode;
  logic            zero;
  logic            sign;
  logic [2:0]      state;
  logic            PCWre;
  logic [1:0]      PCSrc;
  logic            IRWre;
  logic            ALUSrcA;
  logic            ALUSrcB;
  logic [2:0]      ALUOp;
  logic            ExtSel;
  logic [1:0]      RegDst;
  logic            WrRegDSrc;
  logic            DBDataSrc;
  logic            RegWre;
  logic            mRD;
  logic            mWR;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic            illegal;

  modport master (
    input  opcode, zero, sign,
    output state, PCWre, PCSrc, IRWre, ALUSrcA, ALUSrcB, ALUOp, ExtSel,
           RegDst, WrRegDSrc, DBDataSrc, RegWre, mRD, mWR, illegal
  );
  modport slave (
    output opcode, zero, sign,
    input  state, PCWre, PCSrc, IRWre, ALUSrcA, ALUSrcB, ALUOp, ExtSel,
           RegDst, WrRegDSrc, DBDataSrc, RegWre, mRD, mWR, illegal
  );
`else
  modport master (
    input  opcode, zero, sign,
    output state, PCWre, PCSrc, IRWre, ALUSrcA, ALUSrcB, ALUOp, ExtSel,
           RegDst, WrRegDSrc, DBDataSrc, RegWre, mRD, mWR
  );
  modport slave (
    output opcode, zero, sign,
    input  state, PCWre, PCSrc, IRWre, ALUSrcA, ALUSrcB, ALUOp, ExtSel,
           RegDst, WrRegDSrc, DBDataSrc, RegWre, mRD, mWR
  );
`endif
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control unit: IF/ID/EXE/MEM/WB/HALT sequencer with combinational controls.
// Optional CTRL_ILLEGAL_TRAP_EN traps unknown opcodes into HALT and raises illegal.
module multi_cycle_ctrl #(
  parameter int OP_W = 6
) (
  input logic                 CLK,
  input logic                 Reset,
  multi_cycle_ctrl_if.master  bus
);

  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(6'b000001);
  localparam logic [OP_W-1:0] OP_ADDIU = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(6'b010000);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b010010);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(6'b100110);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b110000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b110001);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b110100);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b110101);
  localparam logic [OP_W-1:0] OP_BLTZ  = OP_W'(6'b110110);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b111000);
  localparam logic [OP_W-1:0] OP_JR    = OP_W'(6'b111001);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'b111010);
  localparam logic [OP_W-1:0] OP_HALT  = OP_W'(6'b111111);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b101
  } state_e;

  state_e state_q, state_d;

  logic       pcWre, irWre, aluSrcB, extSel, wrRegDSrc, dbDataSrc, regWre, mRd, mWr;
  logic [1:0] pcSrc, regDst;
  logic [2:0] aluOp;
  logic       isRType;

  assign isRType = (bus.opcode == OP_ADD) || (bus.opcode == OP_SUB) ||
                   (bus.opcode == OP_AND) || (bus.opcode == OP_SLT);

  always_ff @(posedge CLK) begin
    if (!Reset) state_q <= S_IF;
    else        state_q <= state_d;
  end

  // Next state and controls; everything is held at 0 while Reset is low.
  always_comb begin
    state_d   = state_q;
    pcWre     = 1'b0;
    pcSrc     = 2'b00;
    irWre     = 1'b0;
    aluSrcB   = 1'b0;
    aluOp     = 3'b000;
    extSel    = 1'b0;
    regDst    = 2'b00;
    wrRegDSrc = 1'b0;
    dbDataSrc = 1'b0;
    regWre    = 1'b0;
    mRd       = 1'b0;
    mWr       = 1'b0;
    case (state_q)
      S_IF: begin
        irWre   = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        case (bus.opcode)
          OP_J:    begin pcWre = 1'b1; pcSrc = 2'b11; state_d = S_IF; end
          OP_JR:   begin pcWre = 1'b1; pcSrc = 2'b10; state_d = S_IF; end
          OP_JAL:  begin pcWre = 1'b1; pcSrc = 2'b11; regWre = 1'b1; state_d = S_IF; end
          OP_HALT: state_d = S_HALT;
          OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ORI, OP_SLT,
          OP_SW, OP_LW, OP_BEQ, OP_BNE, OP_BLTZ: state_d = S_EXE;
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            state_d = S_HALT;
`else
            pcWre   = 1'b1;
            state_d = S_IF;
`endif
          end
        endcase
      end
      S_EXE: begin
        extSel  = (bus.opcode != OP_ORI);
        state_d = S_WB;
        case (bus.opcode)
          OP_SUB:   aluOp = 3'b001;
          OP_AND:   aluOp = 3'b010;
          OP_SLT:   aluOp = 3'b100;
          OP_ADDIU: aluSrcB = 1'b1;
          OP_ORI:   begin aluOp = 3'b011; aluSrcB = 1'b1; end
          OP_LW, OP_SW: begin aluSrcB = 1'b1; state_d = S_MEM; end
          OP_BEQ:   begin aluOp = 3'b001; pcWre = 1'b1; pcSrc = {1'b0, bus.zero};  state_d = S_IF; end
          OP_BNE:   begin aluOp = 3'b001; pcWre = 1'b1; pcSrc = {1'b0, !bus.zero}; state_d = S_IF; end
          OP_BLTZ:  begin aluOp = 3'b001; pcWre = 1'b1; pcSrc = {1'b0, bus.sign};  state_d = S_IF; end
          default:  aluOp = 3'b000;
        endcase
      end
      S_MEM: begin
        if (bus.opcode == OP_SW) begin
          mWr     = 1'b1;
          pcWre   = 1'b1;
          state_d = S_IF;
        end else begin
          mRd     = 1'b1;
          state_d = S_WB;
        end
      end
      S_WB: begin
        regWre    = 1'b1;
        wrRegDSrc = 1'b1;
        pcWre     = 1'b1;
        regDst    = isRType ? 2'b10 : 2'b01;
        dbDataSrc = (bus.opcode == OP_LW);
        state_d   = S_IF;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  assign bus.state     = Reset ? state_q : 3'b000;
  assign bus.PCWre     = Reset & pcWre;
  assign bus.PCSrc     = Reset ? pcSrc : 2'b00;
  assign bus.IRWre     = Reset & irWre;
  assign bus.ALUSrcA   = 1'b0;
  assign bus.ALUSrcB   = Reset & aluSrcB;
  assign bus.ALUOp     = Reset ? aluOp : 3'b000;
  assign bus.ExtSel    = Reset & extSel;
  assign bus.RegDst    = Reset ? regDst : 2'b00;
  assign bus.WrRegDSrc = Reset & wrRegDSrc;
  assign bus.DBDataSrc = Reset & dbDataSrc;
  assign bus.RegWre    = Reset & regWre;
  assign bus.mRD       = Reset & mRd;
  assign bus.mWR       = Reset & mWr;

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic known;
  always_comb begin
    case (bus.opcode)
      OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ORI, OP_SLT, OP_SW, OP_LW,
      OP_BEQ, OP_BNE, OP_BLTZ, OP_J, OP_JR, OP_JAL, OP_HALT: known = 1'b1;
      default: known = 1'b0;
    endcase
  end
  // The IR is not reloaded in HALT, so the trapping opcode is still visible here.
  assign bus.illegal = Reset && (state_q == S_HALT) && !known;
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Table-driven, scoreboarded bench for multi_cycle_ctrl, plus cycle-count sequences.
// Builds with or without CTRL_ILLEGAL_TRAP_EN.
module tb_multi_cycle_ctrl;

  localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND = 6'b010000, OP_ORI = 6'b010010, OP_SLT = 6'b100110;
  localparam logic [5:0] OP_SW = 6'b110000, OP_LW = 6'b110001, OP_BEQ = 6'b110100;
  localparam logic [5:0] OP_BNE = 6'b110101, OP_BLTZ = 6'b110110, OP_J = 6'b111000;
  localparam logic [5:0] OP_JR = 6'b111001, OP_JAL = 6'b111010, OP_HALT = 6'b111111;
  localparam logic [5:0] OP_BAD = 6'b101010;

  typedef struct packed {
    logic [2:0] state;
    logic       pcWre;
    logic [1:0] pcSrc;
    logic       irWre;
    logic       aluSrcA;
    logic       aluSrcB;
    logic [2:0] aluOp;
    logic       extSel;
    logic [1:0] regDst;
    logic       wrRegDSrc;
    logic       dbDataSrc;
    logic       regWre;
    logic       mRd;
    logic       mWr;
    logic       illegal;
  } ctl_t;

  typedef struct packed {
    logic       rst;
    logic [5:0] op;
    logic       z;
    logic       s;
    ctl_t       exp;
  } vec_t;

  logic clock;
  logic Reset;
  int   total;
  int   bad;
  vec_t vecs[$];
  ctl_t expQ[$];

  multi_cycle_ctrl_if #(.OP_W(6)) bus();
  multi_cycle_ctrl #(.OP_W(6)) dut (.CLK(clock), .Reset(Reset), .bus(bus.master));

  // Free-running 10-unit clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case a sequence never returns.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic ctl_t mk(logic [2:0] st, logic pw, logic [1:0] ps, logic ir, logic sb,
                              logic [2:0] aop, logic ex, logic [1:0] rd, logic wd, logic db,
                              logic rw, logic mr, logic mw, logic il);
    ctl_t c;
    c = '{st, pw, ps, ir, 1'b0, sb, aop, ex, rd, wd, db, rw, mr, mw, il};
    return c;
  endfunction

  function automatic ctl_t cZero();   return mk(0,0,2'b00,0,0,3'b000,0,2'b00,0,0,0,0,0,0); endfunction
  function automatic ctl_t cIf();     return mk(0,0,2'b00,1,0,3'b000,0,2'b00,0,0,0,0,0,0); endfunction
  function automatic ctl_t cId();     return mk(1,0,2'b00,0,0,3'b000,0,2'b00,0,0,0,0,0,0); endfunction
  function automatic ctl_t cJmp(logic [1:0] ps, logic jal);
    return mk(1,1,ps,0,0,3'b000,0,2'b00,0,0,jal,0,0,0);
  endfunction
  function automatic ctl_t cExe(logic [2:0] aop, logic sb, logic ex);
    return mk(2,0,2'b00,0,sb,aop,ex,2'b00,0,0,0,0,0,0);
  endfunction
  function automatic ctl_t cBr(logic taken);
    return mk(2,1,{1'b0, taken},0,0,3'b001,1,2'b00,0,0,0,0,0,0);
  endfunction
  function automatic ctl_t cMemLw();  return mk(3,0,2'b00,0,0,3'b000,0,2'b00,0,0,0,1,0,0); endfunction
  function automatic ctl_t cMemSw();  return mk(3,1,2'b00,0,0,3'b000,0,2'b00,0,0,0,0,1,0); endfunction
  function automatic ctl_t cWb(logic [1:0] rd, logic db);
    return mk(4,1,2'b00,0,0,3'b000,0,rd,1,db,1,0,0,0);
  endfunction
  function automatic ctl_t cHalt(logic il); return mk(5,0,2'b00,0,0,3'b000,0,2'b00,0,0,0,0,0,il); endfunction

  task automatic addVec(input logic r, input logic [5:0] op, input logic z, input logic s, input ctl_t e);
    vec_t v;
    v = '{r, op, z, s, e};
    vecs.push_back(v);
  endtask

  function automatic ctl_t sampleDut();
    ctl_t c;
    c.state = bus.state;         c.pcWre = bus.PCWre;         c.pcSrc = bus.PCSrc;
    c.irWre = bus.IRWre;         c.aluSrcA = bus.ALUSrcA;     c.aluSrcB = bus.ALUSrcB;
    c.aluOp = bus.ALUOp;         c.extSel = bus.ExtSel;       c.regDst = bus.RegDst;
    c.wrRegDSrc = bus.WrRegDSrc; c.dbDataSrc = bus.DBDataSrc; c.regWre = bus.RegWre;
    c.mRd = bus.mRD;             c.mWr = bus.mWR;
`ifdef CTRL_ILLEGAL_TRAP_EN
    c.illegal = bus.illegal;
`else
    c.illegal = 1'b0;
`endif
    return c;
  endfunction

  // Drive one cycle's inputs and queue what the outputs must be during that cycle.
  task automatic applyStimulus(input vec_t v);
    Reset      = v.rst;
    bus.opcode = v.op;
    bus.zero   = v.z;
    bus.sign   = v.s;
    expQ.push_back(v.exp);
  endtask

  task automatic checkOutput(input int idx);
    ctl_t act;
    ctl_t exp;
    act = sampleDut();
    total++;
    if (expQ.size() == 0) begin
      bad++;
      $display("[TB] FAIL vec%0d: got %h required queued expectation", idx, act);
    end else begin
      exp = expQ.pop_front();
      if (act !== exp) begin
        bad++;
        $display("[TB] FAIL vec%0d: got %h required %h (state %0d/%0d)", idx, act, exp, act.state, exp.state);
      end
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Reset into IF, then count cycles and PCWre pulses until the state returns to IF.
  task automatic runCpi(input logic [5:0] op, input int expCycles, input string name);
    int cyc;
    int pulses;
    @(negedge clock);
    Reset = 1'b0;
    @(negedge clock);
    Reset = 1'b1;
    bus.opcode = op;
    bus.zero = 1'b1;
    bus.sign = 1'b0;
    #2;
    cyc = 0;
    pulses = 0;
    do begin
      pulses += int'(bus.PCWre);
      cyc++;
      @(negedge clock);
      #2;
    end while (bus.state != 3'b000 && cyc < 12);
    checkValue({name, "_cycles"}, cyc, expCycles);
    checkValue({name, "_pcwre_pulses"}, pulses, 1);
  endtask

  initial begin
    total = 0;
    bad = 0;
    Reset = 1'b0;
    bus.opcode = OP_ADD;
    bus.zero = 1'b0;
    bus.sign = 1'b0;

    for (int i = 0; i < 3; i++) addVec(0, OP_ADD, 0, 0, cZero());
    addVec(1, OP_ADD, 0, 0, cIf());  addVec(1, OP_ADD, 1, 1, cId());
    addVec(1, OP_ADD, 1, 1, cExe(3'b000, 0, 1)); addVec(1, OP_ADD, 0, 0, cWb(2'b10, 0));
    addVec(1, OP_LW, 0, 0, cIf());   addVec(1, OP_LW, 0, 0, cId());
    addVec(1, OP_LW, 0, 0, cExe(3'b000, 1, 1));  addVec(1, OP_LW, 1, 0, cMemLw());
    addVec(1, OP_LW, 0, 0, cWb(2'b01, 1));
    addVec(1, OP_SW, 0, 0, cIf());   addVec(1, OP_SW, 0, 0, cId());
    addVec(1, OP_SW, 0, 0, cExe(3'b000, 1, 1));  addVec(1, OP_SW, 0, 0, cMemSw());
    addVec(1, OP_BEQ, 0, 0, cIf());  addVec(1, OP_BEQ, 1, 0, cId());  addVec(1, OP_BEQ, 1, 0, cBr(1));
    addVec(1, OP_BEQ, 0, 0, cIf());  addVec(1, OP_BEQ, 0, 0, cId());  addVec(1, OP_BEQ, 0, 1, cBr(0));
    addVec(1, OP_BNE, 0, 0, cIf());  addVec(1, OP_BNE, 0, 0, cId());  addVec(1, OP_BNE, 0, 0, cBr(1));
    addVec(1, OP_BLTZ, 0, 0, cIf()); addVec(1, OP_BLTZ, 0, 0, cId()); addVec(1, OP_BLTZ, 0, 1, cBr(1));
    addVec(1, OP_BLTZ, 0, 0, cIf()); addVec(1, OP_BLTZ, 0, 0, cId()); addVec(1, OP_BLTZ, 1, 0, cBr(0));
    addVec(1, OP_ORI, 0, 0, cIf());  addVec(1, OP_ORI, 0, 0, cId());
    addVec(1, OP_ORI, 0, 0, cExe(3'b011, 1, 0)); addVec(1, OP_ORI, 0, 0, cWb(2'b01, 0));
    addVec(1, OP_AND, 0, 0, cIf());  addVec(1, OP_AND, 0, 0, cId());
    addVec(1, OP_AND, 0, 0, cExe(3'b010, 0, 1)); addVec(1, OP_AND, 0, 0, cWb(2'b10, 0));
    addVec(1, OP_SLT, 0, 0, cIf());  addVec(1, OP_SLT, 0, 0, cId());
    addVec(1, OP_SLT, 0, 0, cExe(3'b100, 0, 1)); addVec(1, OP_SLT, 0, 0, cWb(2'b10, 0));
    addVec(1, OP_SUB, 0, 0, cIf());  addVec(1, OP_SUB, 0, 0, cId());
    addVec(1, OP_SUB, 0, 0, cExe(3'b001, 0, 1)); addVec(1, OP_SUB, 0, 0, cWb(2'b10, 0));
    addVec(1, OP_ADDIU, 0, 0, cIf()); addVec(1, OP_ADDIU, 0, 0, cId());
    addVec(1, OP_ADDIU, 0, 0, cExe(3'b000, 1, 1)); addVec(1, OP_ADDIU, 0, 0, cWb(2'b01, 0));
    addVec(1, OP_JAL, 0, 0, cIf());  addVec(1, OP_JAL, 0, 0, cJmp(2'b11, 1));
    addVec(1, OP_JR, 0, 0, cIf());   addVec(1, OP_JR, 0, 0, cJmp(2'b10, 0));
    addVec(1, OP_J, 0, 0, cIf());    addVec(1, OP_J, 0, 0, cJmp(2'b11, 0));
    // Reset mid-instruction: lw is abandoned in its MEM cycle.
    addVec(1, OP_LW, 0, 0, cIf());   addVec(1, OP_LW, 0, 0, cId());
    addVec(1, OP_LW, 0, 0, cExe(3'b000, 1, 1)); addVec(0, OP_LW, 0, 0, cZero());
    addVec(1, OP_BAD, 0, 0, cIf());
`ifdef CTRL_ILLEGAL_TRAP_EN
    addVec(1, OP_BAD, 0, 0, cId());
    for (int i = 0; i < 3; i++) addVec(1, OP_BAD, 1, 1, cHalt(1));
    addVec(0, OP_BAD, 0, 0, cZero());
`else
    addVec(1, OP_BAD, 0, 0, cJmp(2'b00, 0));
    addVec(1, OP_BAD, 0, 0, cIf());
    addVec(0, OP_BAD, 0, 0, cZero());
`endif
    addVec(1, OP_HALT, 0, 0, cIf()); addVec(1, OP_HALT, 0, 0, cId());
    for (int i = 0; i < 20; i++) addVec(1, OP_HALT, i[0], i[1], cHalt(0));
    addVec(0, OP_HALT, 0, 0, cZero());
    addVec(1, OP_ADD, 0, 0, cIf());

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      applyStimulus(vecs[i]);
      #2;
      checkOutput(i);
    end
    checkValue("scoreboard_empty", expQ.size(), 0);

    runCpi(OP_ADD, 4, "cpi_add");
    runCpi(OP_LW, 5, "cpi_lw");
    runCpi(OP_SW, 4, "cpi_sw");
    runCpi(OP_BEQ, 3, "cpi_beq");
    runCpi(OP_JAL, 2, "cpi_jal");
    runCpi(OP_J, 2, "cpi_j");
`ifndef CTRL_ILLEGAL_TRAP_EN
    runCpi(OP_BAD, 2, "cpi_nop");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Main control unit of the multi-cycle CPU. It sequences every instruction through fetch, decode, execute, memory and write-back states. In each state it drives the datapath enables and selects, including the 2-bit `PCSrc` that feeds the next-PC 4:1 select mux directly upstream of the PC register. It consumes the 6-bit opcode from the instruction register and the ALU `zero`/`sign` flags.

## Interface
- `OP_W`, default 6: opcode width.
- `CLK`, input, 1: rising-edge clock.
- `Reset`, input, 1: reset, synchronous, active-low.
- `opcode`, input, OP_W: IR[31:26]. Stable from the cycle after IF until the next IF.
- `zero`, input, 1: ALU result == 0, valid in EXE.
- `sign`, input, 1: ALU result[31], valid in EXE.
- `state`, output, 3: current state, for debug.
- `PCWre`, output, 1: PC register load enable.
- `PCSrc`, output, 2: next-PC select. 00 PC+4, 01 branch target, 10 rs (jr), 11 jump target.
- `IRWre`, output, 1: IR load enable.
- `ALUSrcA`, output, 1: 1 selects sa. 0 selects rs.
- `ALUSrcB`, output, 1: 1 selects the extended immediate. 0 selects rt.
- `ALUOp`, output, 3: 000 add, 001 sub, 010 and, 011 or, 100 slt.
- `ExtSel`, output, 1: 1 sign-extend, 0 zero-extend.
- `RegDst`, output, 2: 00 selects $31, 01 rt, 10 rd.
- `WrRegDSrc`, output, 1: 0 selects PC+4 (jal), 1 selects the DB data.
- `DBDataSrc`, output, 1: 0 selects the ALU result, 1 selects memory data.
- `RegWre`, output, 1: register-file write enable.
- `mRD`, output, 1: data-memory read.
- `mWR`, output, 1: data-memory write.
- `illegal`, output, 1: unknown opcode flag. Exists only with CTRL_ILLEGAL_TRAP_EN.

## Operation
- Opcodes:
  - add 000000, sub 000001, addiu 000010
  - and 010000, ori 010010, slt 100110
  - sw 110000, lw 110001
  - beq 110100, bne 110101, bltz 110110
  - j 111000, jr 111001, jal 111010
  - halt 111111
- States: IF 000, ID 001, EXE 010, MEM 011, WB 100, HALT 101. The 3-bit state register is the only storage.
- IF: `IRWre`=1. Next state is ID.
- ID:
  - j, jr, jal: `PCWre`=1 with `PCSrc` 11, 10 and 11 respectively. Next state is IF.
  - jal additionally asserts `RegWre`=1, `RegDst`=00 and `WrRegDSrc`=0 in the same cycle.
  - halt: next state is HALT.
  - Any other known opcode: next state is EXE.
- EXE:
  - ALU controls are decoded from the opcode. `ExtSel`=0 for ori only.
  - beq and bne use sub and are taken when `zero`=1 (beq) or `zero`=0 (bne).
  - bltz compares rs against $0 with sub and is taken when `sign`=1.
  - Branches: `PCWre`=1, `PCSrc`=01 if taken, else 00. Next state is IF.
  - lw, sw: add with the immediate. Next state is MEM.
  - All others: next state is WB.
- MEM:
  - sw: `mWR`=1, `PCWre`=1, `PCSrc`=00. Next state is IF.
  - lw: `mRD`=1. Next state is WB.
- WB: `RegWre`=1, `WrRegDSrc`=1, `PCWre`=1, `PCSrc`=00.
  - `RegDst`=10 for R-type and 01 for I-type.
  - `DBDataSrc`=1 for lw, else 0.
  - Next state is IF.
- HALT: all enables are 0. The state holds until `Reset`=0.
- Outputs are combinational from state, opcode and flags. `PCWre` is asserted in exactly one cycle per instruction: the final cycle.
- Any output not specified for a state is driven to 0.

## Timing
- Reset:
  - While `Reset`=0, all outputs are forced to 0 combinationally.
  - On the edge sampled with `Reset`=0, state becomes IF. This also applies mid-instruction, including from HALT.
  - The first edge with `Reset`=1 sees `IRWre`=1.
- Cycles per instruction:
  - jump/jal: 2 (IF, ID).
  - branch: 3.
  - sw: 4.
  - ALU ops: 4.
  - lw: 5.
  - halt: enters HALT at the 3rd edge.
- `zero` and `sign` are sampled combinationally in EXE only. They are ignored in all other states.
- Opcode changes outside IF are ignored, because the opcode is only decoded as a registered IR value.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined:
  - An unknown opcode in ID forces next state HALT and asserts `illegal`=1 while in HALT.
  - `illegal` clears on reset.
- Not defined:
  - An unknown opcode executes as a NOP: in ID, `PCWre`=1, `PCSrc`=00, next state IF. 2 cycles.
  - The `illegal` port is absent.

## Test plan
- Reset held low for 3 cycles, then released: all outputs are 0 during reset. The state sequence is 000, 001, 010, 100, 000 for add.
- lw then sw: states IF, ID, EXE, MEM, WB (`mRD`=1 in MEM, `DBDataSrc`=1 and `RegWre`=1 in WB), then IF, ID, EXE, MEM with `mWR`=1. Each `PCWre` pulse is 1 cycle.
- beq with `zero`=1, then `zero`=0; bltz with `sign`=1: `PCSrc` is 01, 00, 01 respectively in EXE, with `PCWre`=1.
- jal: in ID, `PCWre`=1, `PCSrc`=11, `RegWre`=1, `RegDst`=00, `WrRegDSrc`=0. Returns to IF after 2 cycles. jr gives `PCSrc`=10.
- halt: the state stays 101 for 20 cycles with all enables 0. `Reset`=0 for one edge brings the state to 000.
- Opcode 101010 ×2 builds: with the macro, HALT and `illegal`=1; without it, a 2-cycle NOP with `PCSrc`=00.
